// File: rtl/cmos_capture_gen2_if.sv
// cmos_capture_gen2_if: DVP sensor bus plus packed-pixel stream.
// master = capture block, slave = sensor model / pixel consumer.
interface cmos_capture_gen2_if #(
  parameter int IN_W = 8,
  parameter int BPP  = 2
);
  logic [IN_W-1:0]     CMOS_iDATA;
  logic                CMOS_VSYNC;
  logic                CMOS_HREF;
  logic [IN_W*BPP-1:0] oPix_Data;
  logic                oPix_Valid;
  logic                oSof;
  logic                oEol;
  logic [11:0]         oX;
  logic [11:0]         oY;
  logic                oFrame_Act;
  logic                oLine_Err;
  logic                oFrame_Err;
  logic [7:0]          oFPS;

  modport master (
    input  CMOS_iDATA, CMOS_VSYNC, CMOS_HREF,
    output oPix_Data, oPix_Valid, oSof, oEol,
    output oX, oY, oFrame_Act,
    output oLine_Err, oFrame_Err, oFPS
  );

  modport slave (
    output CMOS_iDATA, CMOS_VSYNC, CMOS_HREF,
    input  oPix_Data, oPix_Valid, oSof, oEol,
    input  oX, oY, oFrame_Act,
    input  oLine_Err, oFrame_Err, oFPS
  );
endinterface

// File: rtl/cmos_capture_gen2.sv
// cmos_capture_gen2: DVP camera capture front end.
// Packs sensor beats into pixels, tags geometry, counts FPS.
module cmos_capture_gen2 #(
  parameter int IN_W       = 8,
  parameter int BPP        = 2,
  parameter int MSB_FIRST  = 1,
  parameter int VS_ACT_LOW = 1,
  parameter int SKIP_FRM   = 12,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int CLK_HZ     = 25000000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic Init_Done,
  input  logic iCap_En,
  cmos_capture_gen2_if.master bus
);

  localparam int PW = IN_W * BPP;
  localparam int WW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(CLK_HZ - 1);
  localparam logic [1:0]  BEAT_LAST = 2'(BPP - 1);
  localparam logic [11:0] H_LEN     = 12'(H_ACT);
  localparam logic [11:0] V_LEN     = 12'(V_ACT);
  localparam logic [11:0] X_LAST    = 12'(H_ACT - 1);
  localparam logic [7:0]  SKIP_N    = 8'(SKIP_FRM);

  typedef enum logic [1:0] {
    S_WAIT_INIT,
    S_SKIP,
    S_WAIT_SOF,
    S_ACTIVE
  } state_t;

  function automatic logic [11:0] sat12(
    input logic [11:0] v
  );
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t          state_q, state_d;
  logic            vs_q, vs_d;
  logic            cap_q, cap_d;
  logic [1:0]      beat_q, beat_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [7:0]      skip_q, skip_d;
  logic [11:0]     xc_q, xc_d;
  logic [11:0]     yc_q, yc_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eol_q, eol_d;
  logic [11:0]     ox_q, ox_d;
  logic [11:0]     oy_q, oy_d;
  logic            lerr_q, lerr_d;
  logic            ferr_q, ferr_d;
  logic [WW-1:0]   win_q, win_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic [7:0]      fps_q, fps_d;

  logic            vs_act;
  logic            sof_ev;
  logic            fe_ev;
  logic            is_act;
  logic            line_end;
  logic            last;
  logic [1:0]      slot;
  logic [11:0]     lines;
  logic [7:0]      fc_inc;

  assign vs_act = bus.CMOS_VSYNC ^ (VS_ACT_LOW != 0);
  assign sof_ev = vs_act & ~vs_q;
  assign fe_ev  = ~vs_act & vs_q;
  assign is_act = (state_q == S_ACTIVE) & Init_Done;

  // Frame sequencing: wait init, skip frames, gate on capture enable.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    unique case (state_q)
      S_WAIT_INIT: begin
        if (Init_Done) begin
          skip_d  = 8'd0;
          state_d = (SKIP_N == 8'd0) ? S_WAIT_SOF : S_SKIP;
        end
      end
      S_SKIP: begin
        if (fe_ev) begin
          skip_d = skip_q + 8'd1;
          if (skip_d == SKIP_N) state_d = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (sof_ev && iCap_En) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (fe_ev) state_d = S_WAIT_SOF;
      end
      default: state_d = S_WAIT_INIT;
    endcase
    if (!Init_Done) state_d = S_WAIT_INIT;
  end

  // Beat packing, coordinates and geometry checks.
  always_comb begin
    vs_d     = vs_act;
    cap_d    = is_act & vs_act & bus.CMOS_HREF;
    line_end = is_act & cap_q & ~cap_d;
    last     = cap_d & (beat_q == BEAT_LAST);
    slot     = (MSB_FIRST != 0) ? BEAT_LAST - beat_q
                                : beat_q;
    lines    = line_end ? sat12(yc_q) : yc_q;
    acc_d    = acc_q;
    beat_d   = 2'd0;
    xc_d     = xc_q;
    yc_d     = yc_q;
    pix_d    = pix_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    ox_d     = ox_q;
    oy_d     = oy_q;
    lerr_d   = 1'b0;
    ferr_d   = is_act & fe_ev & (lines != V_LEN);
    if (cap_d) begin
      acc_d[slot*IN_W +: IN_W] = bus.CMOS_iDATA;
      beat_d = last ? 2'd0 : beat_q + 2'd1;
    end
    if (last) begin
      pix_d   = acc_d;
      valid_d = 1'b1;
      ox_d    = xc_q;
      oy_d    = yc_q;
      sof_d   = (xc_q == 12'd0) && (yc_q == 12'd0);
      eol_d   = (xc_q == X_LAST);
      xc_d    = sat12(xc_q);
    end
    if (line_end) begin
      lerr_d = (xc_q != H_LEN) || (beat_q != 2'd0);
      xc_d   = 12'd0;
      yc_d   = lines;
    end
    if (sof_ev) begin
      xc_d = 12'd0;
      yc_d = 12'd0;
    end
  end

  // One-second frame-rate window.
  always_comb begin
    win_d  = win_q;
    fcnt_d = fcnt_q;
    fps_d  = fps_q;
    fc_inc = (fe_ev && fcnt_q != 8'hFF)
           ? fcnt_q + 8'd1 : fcnt_q;
    if (!Init_Done) begin
      win_d  = '0;
      fcnt_d = 8'd0;
      fps_d  = 8'd0;
    end else if (win_q == WIN_LAST) begin
      win_d  = '0;
      fcnt_d = 8'd0;
      fps_d  = fc_inc;
    end else begin
      win_d  = win_q + 1'b1;
      fcnt_d = fc_inc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_WAIT_INIT;
      vs_q    <= 1'b0;
      cap_q   <= 1'b0;
      beat_q  <= 2'd0;
      acc_q   <= '0;
      skip_q  <= 8'd0;
      xc_q    <= 12'd0;
      yc_q    <= 12'd0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      ox_q    <= 12'd0;
      oy_q    <= 12'd0;
      lerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      win_q   <= '0;
      fcnt_q  <= 8'd0;
      fps_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      cap_q   <= cap_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      skip_q  <= skip_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      lerr_q  <= lerr_d;
      ferr_q  <= ferr_d;
      win_q   <= win_d;
      fcnt_q  <= fcnt_d;
      fps_q   <= fps_d;
    end
  end

  assign bus.oPix_Data  = pix_q;
  assign bus.oPix_Valid = valid_q;
  assign bus.oSof       = sof_q;
  assign bus.oEol       = eol_q;
  assign bus.oX         = ox_q;
  assign bus.oY         = oy_q;
  assign bus.oFrame_Act = (state_q == S_ACTIVE);
  assign bus.oLine_Err  = lerr_q;
  assign bus.oFrame_Err = ferr_q;
  assign bus.oFPS       = fps_q;

endmodule

// File: tb/tb_cmos_capture_gen2.sv
// tb_cmos_capture_gen2: directed bench for the capture block.
// Two instances cover BPP=2/MSB-first and BPP=3/LSB-first.
module tb_cmos_capture_gen2;

  localparam logic VA = 1'b0;
  localparam logic VI = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic init1, cap1;
  logic init2, cap2;

  cmos_capture_gen2_if #(.IN_W(8), .BPP(2)) b1();
  cmos_capture_gen2_if #(.IN_W(8), .BPP(3)) b2();

  cmos_capture_gen2 #(
    .IN_W(8), .BPP(2), .MSB_FIRST(1),
    .VS_ACT_LOW(1), .SKIP_FRM(2),
    .H_ACT(4), .V_ACT(2), .CLK_HZ(100)
  ) u1 (
    .iCLK(clk), .iRST_N(rst_n),
    .Init_Done(init1), .iCap_En(cap1),
    .bus(b1.master)
  );

  cmos_capture_gen2 #(
    .IN_W(8), .BPP(3), .MSB_FIRST(0),
    .VS_ACT_LOW(1), .SKIP_FRM(0),
    .H_ACT(1), .V_ACT(1), .CLK_HZ(1000)
  ) u2 (
    .iCLK(clk), .iRST_N(rst_n),
    .Init_Done(init2), .iCap_En(cap2),
    .bus(b2.master)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    pix_t       exp;
  } vec_t;

  pix_t pq[$];
  int   lerr_n = 0;
  int   ferr_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Pixel / pulse monitor for u1, sampled mid-cycle.
  always @(negedge clk) begin
    if (b1.oPix_Valid)
      pq.push_back({b1.oPix_Data, b1.oX, b1.oY,
                    b1.oSof, b1.oEol});
    if (b1.oLine_Err) lerr_n++;
    if (b1.oFrame_Err) ferr_n++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic pix_t pix_at(input int i);
    if (i < pq.size()) return pq[i];
    return '1;
  endfunction

  function automatic vec_t mk(input logic [7:0] a,
                              input logic [7:0] b,
                              input int x, input int y,
                              input logic s,
                              input logic e);
    vec_t v;
    v.b0  = a;
    v.b1  = b;
    v.exp = {a, b, 12'(x), 12'(y), s, e};
    return v;
  endfunction

  task automatic step(input logic vs, input logic h,
                      input logic [7:0] d);
    b1.CMOS_VSYNC = vs;
    b1.CMOS_HREF  = h;
    b1.CMOS_iDATA = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic vs, input logic h,
                       input logic [7:0] d);
    b2.CMOS_VSYNC = vs;
    b2.CMOS_HREF  = h;
    b2.CMOS_iDATA = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(vs, 1'b0, 8'h00);
  endtask

  task automatic line(input int n,
                      inout logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      step(VA, 1'b1, b);
      b = b + 8'd1;
    end
    idle(2, VA);
  endtask

  task automatic frame(input int nl, input int nb,
                       input logic [7:0] b0);
    logic [7:0] b;
    b = b0;
    idle(2, VA);
    for (int l = 0; l < nl; l++) line(nb, b);
    idle(3, VI);
  endtask

  vec_t t1[8];
  int   base, lb, fb;
  logic [7:0] bb;

  initial begin
    t1[0] = mk(8'h01, 8'h02, 0, 0, 1'b1, 1'b0);
    t1[1] = mk(8'h03, 8'h04, 1, 0, 1'b0, 1'b0);
    t1[2] = mk(8'h05, 8'h06, 2, 0, 1'b0, 1'b0);
    t1[3] = mk(8'h07, 8'h08, 3, 0, 1'b0, 1'b1);
    t1[4] = mk(8'h09, 8'h0A, 0, 1, 1'b0, 1'b0);
    t1[5] = mk(8'h0B, 8'h0C, 1, 1, 1'b0, 1'b0);
    t1[6] = mk(8'h0D, 8'h0E, 2, 1, 1'b0, 1'b0);
    t1[7] = mk(8'h0F, 8'h10, 3, 1, 1'b0, 1'b1);

    rst_n = 1'b0;
    init1 = 1'b1;
    cap1  = 1'b1;
    init2 = 1'b1;
    cap2  = 1'b1;
    b1.CMOS_VSYNC = VI;
    b1.CMOS_HREF  = 1'b0;
    b1.CMOS_iDATA = 8'h00;
    b2.CMOS_VSYNC = VI;
    b2.CMOS_HREF  = 1'b0;
    b2.CMOS_iDATA = 8'h00;

    // Reset state
    #22;
    chk("rst_u1", {b1.oPix_Data, b1.oPix_Valid,
        b1.oSof, b1.oEol, b1.oX, b1.oY,
        b1.oFrame_Act, b1.oLine_Err,
        b1.oFrame_Err, b1.oFPS}, 64'd0);
    chk("rst_u2", {b2.oPix_Data, b2.oPix_Valid,
        b2.oFrame_Act, b2.oFPS}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T2: LSB-first, 3 beats per pixel
    step2(VI, 1'b0, 8'h00);
    step2(VI, 1'b0, 8'h00);
    step2(VA, 1'b0, 8'h00);
    step2(VA, 1'b0, 8'h00);
    chk("t2_act", b2.oFrame_Act, 1);
    step2(VA, 1'b1, 8'hAA);
    step2(VA, 1'b1, 8'hBB);
    chk("t2_val_bb", b2.oPix_Valid, 0);
    step2(VA, 1'b1, 8'hCC);
    chk("t2_val_cc", b2.oPix_Valid, 1);
    chk("t2_data", b2.oPix_Data, 24'hCCBBAA);
    chk("t2_sof_eol", {b2.oSof, b2.oEol}, 2'b11);
    step2(VA, 1'b0, 8'h00);
    chk("t2_strobe", b2.oPix_Valid, 0);
    step2(VI, 1'b0, 8'h00);
    step2(VI, 1'b0, 8'h00);
    chk("t2_errs", {b2.oLine_Err, b2.oFrame_Err}, 0);

    // T1: two skipped frames, then the table frame
    base = pq.size();
    frame(1, 2, 8'hE0);
    frame(1, 2, 8'hE4);
    chk("skip_pix", pq.size() - base, 0);
    chk("skip_act", b1.oFrame_Act, 0);
    base = pq.size();
    lb = lerr_n;
    fb = ferr_n;
    idle(2, VA);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) begin
        step(VA, 1'b1, t1[4*l+i].b0);
        step(VA, 1'b1, t1[4*l+i].b1);
      end
      idle(2, VA);
    end
    idle(3, VI);
    chk("t1_count", pq.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t1_pix%0d", i),
          pix_at(base + i), t1[i].exp);
    chk("t1_lerr", lerr_n - lb, 0);
    chk("t1_ferr", ferr_n - fb, 0);

    // T3: 9-byte line drops the partial pixel
    base = pq.size();
    lb = lerr_n;
    fb = ferr_n;
    bb = 8'h01;
    idle(2, VA);
    line(9, bb);
    line(8, bb);
    idle(3, VI);
    chk("t3_count", pq.size() - base, 8);
    chk("t3_lerr", lerr_n - lb, 1);
    chk("t3_ferr", ferr_n - fb, 0);
    chk("t3_pix3", pix_at(base + 3),
        {16'h0708, 12'd3, 12'd0, 1'b0, 1'b1});
    chk("t3_pix4", pix_at(base + 4),
        {16'h0A0B, 12'd0, 12'd1, 1'b0, 1'b0});

    // T4: 3 lines -> frame error; then capture off
    base = pq.size();
    lb = lerr_n;
    fb = ferr_n;
    frame(3, 8, 8'h20);
    chk("t4_count", pq.size() - base, 12);
    chk("t4_ferr", ferr_n - fb, 1);
    chk("t4_lerr", lerr_n - lb, 0);
    chk("t4_last", pix_at(base + 11),
        {16'h3637, 12'd3, 12'd2, 1'b0, 1'b1});
    base = pq.size();
    fb = ferr_n;
    cap1 = 1'b0;
    bb = 8'h50;
    idle(2, VA);
    chk("t4_off_act", b1.oFrame_Act, 0);
    line(8, bb);
    line(8, bb);
    idle(3, VI);
    chk("t4_off_pix", pq.size() - base, 0);
    chk("t4_off_ferr", ferr_n - fb, 0);
    cap1 = 1'b1;

    // T6: async reset mid-pixel, then skip again
    idle(2, VA);
    step(VA, 1'b1, 8'h55);
    step(VA, 1'b1, 8'h66);
    step(VA, 1'b1, 8'h77);
    chk("t6_pre_act", b1.oFrame_Act, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst", {b1.oPix_Data, b1.oPix_Valid,
        b1.oSof, b1.oEol, b1.oX, b1.oY,
        b1.oFrame_Act, b1.oLine_Err,
        b1.oFrame_Err, b1.oFPS}, 64'd0);
    b1.CMOS_VSYNC = VI;
    b1.CMOS_HREF  = 1'b0;
    @(posedge clk);
    #1;
    idle(2, VI);
    rst_n = 1'b1;
    idle(2, VI);
    base = pq.size();
    frame(2, 8, 8'h80);
    frame(2, 8, 8'h90);
    chk("t6_skip_pix", pq.size() - base, 0);
    frame(2, 8, 8'h40);
    chk("t6_count", pq.size() - base, 8);
    chk("t6_first", pix_at(base),
        {16'h4041, 12'd0, 12'd0, 1'b1, 1'b0});

    // T5: FPS window of 100 cycles, 30-cycle frames
    init1 = 1'b0;
    idle(3, VI);
    chk("t5_fps_clr", b1.oFPS, 0);
    init1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(20, VA);
      idle(10, VI);
    end
    chk("t5_fps_pre", b1.oFPS, 0);
    idle(12, VI);
    chk("t5_fps", b1.oFPS, 3);

    // T5: drop Init_Done mid-pixel
    idle(2, VA);
    step(VA, 1'b1, 8'h01);
    step(VA, 1'b1, 8'h02);
    step(VA, 1'b1, 8'h03);
    chk("t5_pre_act", b1.oFrame_Act, 1);
    base = pq.size();
    lb = lerr_n;
    fb = ferr_n;
    init1 = 1'b0;
    step(VA, 1'b1, 8'h04);
    step(VA, 1'b1, 8'h05);
    idle(2, VA);
    idle(3, VI);
    chk("t5_drop_act", b1.oFrame_Act, 0);
    chk("t5_drop_fps", b1.oFPS, 0);
    chk("t5_drop_lerr", lerr_n - lb, 0);
    chk("t5_drop_ferr", ferr_n - fb, 0);
    chk("t5_drop_pix", pq.size() - base, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
